multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 46 ++++
 rtl/multicycle_control_retire_counter.sv | 38 +++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-style control unit.
// Holds the state encodings (which are also what the State debug port
// shows), the opcode values the decoder recognises, and the encodings of
// the ALUSrcB, ALUOp and PCSource multiplexer selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    TRAP   = 4'd15
  } state_t;

  // Instruction opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_J     = 6'd2;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retirement tracking for the multicycle control unit.
// An instruction retires on the cycle that hands control back to FETCH from
// any execution state; IDLE->FETCH (leaving reset) and FETCH->FETCH (memory
// wait) are not retirements.
// Ports:
//   CLK, RESET   - clock and asynchronous active-low reset
//   state        - current FSM state
//   state_next   - FSM state that will be loaded on the next edge
//   InstrDone    - one-cycle retire pulse (combinational from the FSM)
//   InstrCount   - free-running retired-instruction count, wraps to 0
module retire_counter
  import multicycle_control_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  state_t      state,
  input  state_t      state_next,
  output logic        InstrDone,
  output logic [31:0] InstrCount
);

  logic [31:0] count_reg;

  // While RESET is low the FSM is held in IDLE, so this pulse is forced low
  // immediately by the asynchronous reset of the state register.
  assign InstrDone = (state_next == FETCH) && (state != IDLE) && (state != FETCH);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_reg <= '0;
    end else if (InstrDone) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign InstrCount = count_reg;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller (fetch / decode / execute FSM).
// Sequences the classic multicycle datapath through R-type, lw, sw, beq,
// bne and j instructions, waiting on MemReady for every memory access and
// parking in a sticky TRAP state on any other opcode.
// Ports:
//   CLK, RESET       - clock and asynchronous active-low reset
//   Opcode           - instruction bits [31:26]
//   Zero             - ALU zero flag (branch condition)
//   MemReady         - current memory read/write has completed
//   PCWrite..PCSource- datapath control strobes and mux selects
//   Trap             - illegal opcode seen (held until reset)
//   InstrDone        - one-cycle pulse per retired instruction
//   InstrCount       - retired instruction count
//   State            - current state encoding for debug
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        Trap,
  output logic        InstrDone,
  output logic [31:0] InstrCount,
  output logic [3:0]  State
);

  state_t     state_reg;
  state_t     state_next;
  logic [5:0] opcode_reg;

  // The opcode is captured as DECODE is left so that MEMADR and BRANCH keep
  // working even if the instruction register is reloaded or changes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg  <= IDLE;
      opcode_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) begin
        opcode_reg <= Opcode;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALUOP_ADD;
    PCSource   = PCSRC_ALU;
    Trap       = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        // PC+4 is computed every fetch cycle, but only committed (together
        // with the instruction) once memory has delivered.
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        IRWrite  = MemReady;
        PCWrite  = MemReady;
        if (MemReady) begin
          state_next = DECODE;
        end
      end

      DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ALUSrcB = SRCB_IMM_SL2;
        ALUOp   = ALUOP_ADD;
        case (Opcode)
          OP_RTYPE:     state_next = EXEC;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP;
        endcase
      end

      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        state_next = (opcode_reg == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          state_next = MEMWB;
        end
      end

      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_next = FETCH;
      end

      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_next = FETCH;
        end
      end

      EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_FUNCT;
        state_next = RWB;
      end

      RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        state_next = FETCH;
      end

      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_REG;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        if (opcode_reg == OP_BEQ) begin
          PCWrite = Zero;
        end else if (opcode_reg == OP_BNE) begin
          PCWrite = ~Zero;
        end
        state_next = FETCH;
      end

      JUMP: begin
        PCSource   = PCSRC_JUMP;
        PCWrite    = 1'b1;
        state_next = FETCH;
      end

      TRAP: begin
        Trap = 1'b1;
      end

      // Unused encodings recover through IDLE rather than lock up.
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign State = state_reg;

  retire_counter u_retire (
    .CLK        (CLK),
    .RESET      (RESET),
    .state      (state_reg),
    .state_next (state_next),
    .InstrDone  (InstrDone),
    .InstrCount (InstrCount)
  );

endmodule
